monitor_mux_sequencer: RTL and testbench

Digital controller directly upstream of the 40:1 monitoring analog mux. It converts a channel request into the mux's 40-bit one-hot Select code, with break-before-make and settling. After settling it handshakes with the monitoring ADC and returns each conversion result tagged with its channel. It supports a single-channel mode and a scan mode that walks channels 0..ScanLast.

---
 rtl/monitor_mux_sequencer_pkg.sv | 9 +
 rtl/monitor_mux_sequencer_if.sv | 27 ++
 rtl/monitor_mux_sequencer.sv | 90 +++++++++
 tb/tb_monitor_mux_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/monitor_mux_sequencer_pkg.sv
// monitor_pkg: shared constants, state type and channel decoder for the monitor mux sequencer
package monitor_pkg;
  localparam int N_CH = 40;
  localparam int CH_W = 6;
  typedef enum logic [2:0] {IDLE, BBM, SETTLE, CONVERT, OUTPUT} mon_state_t;
  function automatic logic [N_CH-1:0] ch2onehot(input logic [CH_W-1:0] ch);
    return (ch < CH_W'(N_CH)) ? ({{(N_CH-1){1'b0}}, 1'b1} << ch) : '0;
  endfunction
endpackage

// File: rtl/monitor_mux_sequencer_if.sv
// monitor_mux_sequencer_if: request, mux select, ADC and result handshake signals
interface monitor_mux_sequencer_if #(parameter int ADC_W = 12);
  logic                             MonEn;
  logic                             Start;
  logic                             ScanMode;
  logic [monitor_pkg::CH_W-1:0]     ChSel;
  logic [monitor_pkg::CH_W-1:0]     ScanLast;
  logic [monitor_pkg::N_CH-1:0]     Select;
  logic                             AdcStart;
  logic                             AdcDone;
  logic [ADC_W-1:0]                 AdcData;
  logic                             ResValid;
  logic                             ResReady;
  logic [ADC_W-1:0]                 ResData;
  logic [monitor_pkg::CH_W-1:0]     ResCh;
  logic                             Busy;
  logic                             ErrCh;
  logic                             ErrTo;
  modport slave (
    input  MonEn, Start, ScanMode, ChSel, ScanLast, AdcDone, AdcData, ResReady,
    output Select, AdcStart, ResValid, ResData, ResCh, Busy, ErrCh, ErrTo
  );
  modport master (
    output MonEn, Start, ScanMode, ChSel, ScanLast, AdcDone, AdcData, ResReady,
    input  Select, AdcStart, ResValid, ResData, ResCh, Busy, ErrCh, ErrTo
  );
endinterface

// File: rtl/monitor_mux_sequencer.sv
// monitor_mux_sequencer: break-before-make mux select, settle, ADC handshake and tagged results
module monitor_mux_sequencer import monitor_pkg::*; #(
  parameter int ADC_W         = 12,
  parameter int SETTLE_CYCLES = 16,
  parameter int ADC_TIMEOUT   = 1024
) (
  input  logic Clk,
  input  logic Reset,
  monitor_mux_sequencer_if.slave bus
);
  localparam int CNT_MAX = (SETTLE_CYCLES > ADC_TIMEOUT) ? SETTLE_CYCLES : ADC_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(ADC_TIMEOUT - 1);
  mon_state_t         r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CH_W-1:0]    r_cur_ch, r_last, r_res_ch;
  logic               r_scan, r_err_ch, r_err_to;
  logic [N_CH-1:0]    r_sel;
  logic [ADC_W-1:0]   r_res_data;
  logic [CH_W-1:0]    w_req_ch;
  logic               w_in_range, w_first, w_done, w_to, w_hs, w_more, w_accept, w_reject;
  assign w_req_ch   = bus.ScanMode ? bus.ScanLast : bus.ChSel;
  assign w_in_range = w_req_ch < CH_W'(N_CH);
  assign w_accept   = r_state == IDLE && bus.MonEn && bus.Start && w_in_range;
  assign w_reject   = r_state == IDLE && bus.MonEn && bus.Start && !w_in_range;
  // one shared down-counter: reload value in CONVERT marks the AdcStart cycle
  assign w_first    = r_state == CONVERT && r_cnt == TO_LD;
  assign w_done     = r_state == CONVERT && bus.MonEn && !w_first && bus.AdcDone;
  assign w_to       = r_state == CONVERT && bus.MonEn && !w_first && !bus.AdcDone && r_cnt == '0;
  assign w_hs       = r_state == OUTPUT && bus.ResReady;
  assign w_more     = r_scan && r_cur_ch < r_last;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_accept ? BBM : IDLE;
      BBM:     w_next = SETTLE;
      SETTLE:  w_next = (r_cnt == '0) ? CONVERT : SETTLE;
      CONVERT: w_next = (w_done || w_to) ? OUTPUT : CONVERT;
      OUTPUT:  w_next = bus.ResReady ? (w_more ? BBM : IDLE) : OUTPUT;
      default: w_next = IDLE;
    endcase
    if (!bus.MonEn) w_next = IDLE;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cur_ch   <= '0;
      r_last     <= '0;
      r_scan     <= 1'b0;
      r_sel      <= '0;
      r_res_data <= '0;
      r_res_ch   <= '0;
      r_err_ch   <= 1'b0;
      r_err_to   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == BBM) ? SET_LD :
                 (r_state == SETTLE && r_cnt == '0) ? TO_LD :
                 (r_cnt != '0) ? r_cnt - 1'b1 : '0;
      r_sel   <= (!bus.MonEn || w_accept || (w_hs && w_more)) ? '0 :
                 (r_state == BBM) ? ch2onehot(r_cur_ch) : r_sel;
      if (w_accept) begin
        r_cur_ch <= bus.ScanMode ? '0 : bus.ChSel;
        r_scan   <= bus.ScanMode;
        r_last   <= bus.ScanLast;
        r_err_ch <= 1'b0;
      end
      if (w_reject) r_err_ch <= 1'b1;
      if (w_hs && w_more) r_cur_ch <= r_cur_ch + 1'b1;
      if (w_done) r_res_data <= bus.AdcData;
      if (w_to) begin
        r_res_data <= '1;
        r_err_to   <= 1'b1;
      end
      if (w_done || w_to) r_res_ch <= r_cur_ch;
    end
  end
  assign bus.Select   = r_sel;
  assign bus.AdcStart = w_first;
  assign bus.ResValid = r_state == OUTPUT;
  assign bus.ResData  = r_res_data;
  assign bus.ResCh    = r_res_ch;
  assign bus.Busy     = r_state != IDLE;
  assign bus.ErrCh    = r_err_ch;
  assign bus.ErrTo    = r_err_to;
  a_sel_onehot0: assert property (@(posedge Clk) disable iff (Reset) $onehot0(r_sel));
  a_settle_hot:  assert property (@(posedge Clk) disable iff (Reset) (r_state == SETTLE) |-> $onehot(r_sel));
endmodule

// File: tb/tb_monitor_mux_sequencer.sv
// tb_monitor_mux_sequencer: directed table vectors plus scan, hold, timeout and MonEn-drop sequences
module tb_monitor_mux_sequencer;
  localparam int SETTLE = 16;
  localparam int TMO    = 1024;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 Clk = ~Clk;
  monitor_mux_sequencer_if #(.ADC_W(12)) bus();
  monitor_mux_sequencer #(.ADC_W(12), .SETTLE_CYCLES(SETTLE), .ADC_TIMEOUT(TMO)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );
  typedef struct {
    logic        rej;
    logic [5:0]  ch;
    logic [11:0] data;
    int          dly;
    int          hold;
    logic [39:0] exp_sel;
  } vec_t;
  vec_t vt[5];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic do_start(input logic scan, input logic [5:0] ch, input logic [5:0] last);
    bus.ScanMode = scan;
    bus.ChSel    = ch;
    bus.ScanLast = last;
    bus.Start    = 1'b1;
    @(negedge Clk);
    bus.Start    = 1'b0;
  endtask
  task automatic wait_adcstart(output int n);
    n = 0;
    while (!bus.AdcStart && n < 200) begin
      @(negedge Clk);
      n++;
    end
  endtask
  task automatic respond(input logic [11:0] data, input int dly);
    for (int i = 0; i < dly; i++) @(negedge Clk);
    bus.AdcDone = 1'b1;
    bus.AdcData = data;
    @(negedge Clk);
    bus.AdcDone = 1'b0;
  endtask
  task automatic handshake();
    bus.ResReady = 1'b1;
    @(negedge Clk);
    bus.ResReady = 1'b0;
  endtask
  task automatic run_vec(input vec_t v);
    int n;
    logic stable;
    do_start(1'b0, v.ch, 6'd0);
    if (v.rej) begin
      chk("reject ErrCh", bus.ErrCh, 1);
      chk("reject Busy", bus.Busy, 0);
      chk("reject Select", bus.Select, v.exp_sel);
      return;
    end
    chk("bbm Select", bus.Select, 0);
    chk("bbm Busy", bus.Busy, 1);
    chk("accept ErrCh", bus.ErrCh, 0);
    @(negedge Clk);
    chk("settle Select", bus.Select, v.exp_sel);
    wait_adcstart(n);
    chk("adcstart latency", n, SETTLE);
    respond(v.data, v.dly);
    chk("ResValid", bus.ResValid, 1);
    chk("ResData", bus.ResData, v.data);
    chk("ResCh", bus.ResCh, v.ch);
    stable = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge Clk);
      stable &= bus.ResValid && bus.ResData == v.data && bus.ResCh == v.ch;
    end
    chk("hold stable", stable, 1);
    handshake();
    chk("done Busy", bus.Busy, 0);
    chk("done ResValid", bus.ResValid, 0);
    chk("idle Select", bus.Select, v.exp_sel);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, m, k, zrun, nz, zbad, pend, cyc;
    logic stable, seen_start, seen_valid;
    vt[0] = '{1'b0, 6'd5,  12'hABC, 10, 0,  40'h20};
    vt[1] = '{1'b0, 6'd0,  12'h001, 1,  3,  40'h1};
    vt[2] = '{1'b0, 6'd17, 12'h5A5, 7,  0,  40'h2_0000};
    vt[3] = '{1'b1, 6'd45, 12'h000, 0,  0,  40'h2_0000};
    vt[4] = '{1'b0, 6'd39, 12'h800, 2,  1,  40'h80_0000_0000};
    bus.MonEn = 1'b1; bus.Start = 1'b0; bus.ScanMode = 1'b0; bus.ChSel = '0; bus.ScanLast = '0;
    bus.AdcDone = 1'b0; bus.AdcData = '0; bus.ResReady = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst Select", bus.Select, 0);
    chk("rst AdcStart", bus.AdcStart, 0);
    chk("rst ResValid", bus.ResValid, 0);
    chk("rst ResData", bus.ResData, 0);
    chk("rst ResCh", bus.ResCh, 0);
    chk("rst Busy", bus.Busy, 0);
    chk("rst ErrCh", bus.ErrCh, 0);
    chk("rst ErrTo", bus.ErrTo, 0);
    Reset = 1'b0;
    @(negedge Clk);
    for (int i = 0; i < 5; i++) run_vec(vt[i]);
    // scan 0..3 with ResReady high; ScanLast/ScanMode changes after Start must not matter
    bus.ResReady = 1'b1;
    do_start(1'b1, 6'd9, 6'd3);
    bus.ScanLast = 6'd1;
    bus.ScanMode = 1'b0;
    k = 0; zrun = 0; nz = 0; zbad = 0; pend = 0; cyc = 0;
    while (bus.Busy && cyc < 500) begin
      if (bus.ResValid) begin
        chk("scan ResCh", bus.ResCh, k);
        chk("scan ResData", bus.ResData, 12'(256 + k));
        k++;
      end
      if (bus.Select == '0) zrun++;
      else begin
        if (zrun != 0) begin
          nz++;
          if (zrun != 1) zbad++;
        end
        zrun = 0;
      end
      bus.AdcDone = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.AdcDone = 1'b1;
          bus.AdcData = 12'(256 + k);
        end
      end
      if (bus.AdcStart) pend = 3;
      @(negedge Clk);
      cyc++;
    end
    bus.AdcDone = 1'b0;
    bus.ResReady = 1'b0;
    chk("scan results", k, 4);
    chk("scan bbm count", nz, 4);
    chk("scan bbm len", zbad, 0);
    chk("scan Busy end", bus.Busy, 0);
    chk("scan Select end", bus.Select, 40'h8);
    // ResReady low for 50 cycles in OUTPUT during a 2-channel scan
    do_start(1'b1, 6'd0, 6'd1);
    wait_adcstart(n);
    respond(12'h0AA, 2);
    chk("hold ResValid", bus.ResValid, 1);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      stable &= bus.ResValid && bus.ResData == 12'h0AA && bus.ResCh == 6'd0 &&
                bus.Select == 40'h1 && !bus.AdcStart;
    end
    chk("hold stable 50", stable, 1);
    handshake();
    chk("hold advance Select", bus.Select, 0);
    chk("hold advance Busy", bus.Busy, 1);
    chk("hold advance ResValid", bus.ResValid, 0);
    wait_adcstart(n);
    chk("hold 2nd latency", n, SETTLE + 1);
    respond(12'h0BB, 1);
    chk("hold 2nd ResCh", bus.ResCh, 1);
    chk("hold 2nd ResData", bus.ResData, 12'h0BB);
    handshake();
    chk("hold end Busy", bus.Busy, 0);
    // ADC never answers
    do_start(1'b0, 6'd2, 6'd0);
    wait_adcstart(n);
    m = 0;
    while (!bus.ResValid && m < 2000) begin
      @(negedge Clk);
      m++;
    end
    chk("timeout latency", m, TMO);
    chk("timeout ResData", bus.ResData, 12'hFFF);
    chk("timeout ResCh", bus.ResCh, 2);
    chk("timeout ErrTo", bus.ErrTo, 1);
    handshake();
    run_vec(vt[0]);
    chk("ErrTo sticky", bus.ErrTo, 1);
    // MonEn drop during SETTLE of a scan
    do_start(1'b1, 6'd0, 6'd3);
    repeat (4) @(negedge Clk);
    chk("monen pre Select", bus.Select, 40'h1);
    bus.MonEn = 1'b0;
    @(negedge Clk);
    chk("monen Select", bus.Select, 0);
    chk("monen Busy", bus.Busy, 0);
    chk("monen AdcStart", bus.AdcStart, 0);
    bus.MonEn = 1'b1;
    seen_start = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.AdcDone = (i == 5);
      bus.AdcData = 12'h123;
      @(negedge Clk);
      seen_start |= bus.AdcStart;
      seen_valid |= bus.ResValid;
    end
    bus.AdcDone = 1'b0;
    chk("monen no AdcStart", seen_start, 0);
    chk("monen no ResValid", seen_valid, 0);
    chk("monen ErrTo kept", bus.ErrTo, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
